// File: rtl/dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_queue
// Description : In-order micro-op dispatch queue between the decoder and the
//               issue stations. Assigns ROB tags at enqueue time and routes
//               the head entry to the ALU, memory or branch station according
//               to its commandType.
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_queue #(
    parameter int DEPTH = 4,
    parameter int UOP_W = 24,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [UOP_W-1:0]         in_uop,
    input  logic [2:0]               in_cmdType,
    input  logic                     rob_alloc_ok,

    output logic                     out_valid,
    output logic [UOP_W-1:0]         out_uop,
    output logic [2:0]               out_cmdType,
    output logic [TAG_W-1:0]         out_tag,
    output logic [1:0]               out_port,

    input  logic                     alu_ready,
    input  logic                     mem_ready,
    input  logic                     br_ready,

    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE   = PTR_W'(1);
    localparam logic [TAG_W-1:0] c_TAG_ONE   = TAG_W'(1);

    localparam logic [1:0] c_PORT_ALU = 2'd0;
    localparam logic [1:0] c_PORT_MEM = 2'd1;
    localparam logic [1:0] c_PORT_BR  = 2'd2;

    // Payload storage; never reset, validity is tracked by r_count alone.
    logic [UOP_W-1:0] r_uop_mem [DEPTH];
    logic [2:0]       r_cmd_mem [DEPTH];
    logic [TAG_W-1:0] r_tag_mem [DEPTH];

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [TAG_W-1:0] r_next_tag;

    logic             w_enq;
    logic             w_deq;
    logic             w_sel_ready;
    logic [1:0]       w_port;

    // Input handshake: depends only on occupancy, ROB space, flush and reset,
    // never on the station ready inputs, to keep the decoder path short.
    assign in_ready = (r_count < c_DEPTH_CNT) & rob_alloc_ok & ~flush & ~reset;
    assign w_enq    = in_valid & in_ready;

    // Head entry is read straight out of storage; there is no bypass from
    // the input, so a fresh entry appears one cycle after it is accepted.
    assign out_valid   = (r_count != '0);
    assign out_uop     = r_uop_mem[r_rd_ptr];
    assign out_cmdType = r_cmd_mem[r_rd_ptr];
    assign out_tag     = r_tag_mem[r_rd_ptr];
    assign out_port    = w_port;
    assign count       = r_count;

    // Station routing decode from the head commandType.
    always_comb begin
        w_port = c_PORT_BR;
        case (r_cmd_mem[r_rd_ptr])
            3'd0, 3'd2, 3'd4: w_port = c_PORT_ALU;
            3'd1:             w_port = c_PORT_MEM;
            default:          w_port = c_PORT_BR;
        endcase
    end

    // Only the station the head is routed to can pull it; the others are
    // ignored so a younger entry can never overtake a blocked head.
    always_comb begin
        w_sel_ready = 1'b0;
        case (w_port)
            c_PORT_ALU: w_sel_ready = alu_ready;
            c_PORT_MEM: w_sel_ready = mem_ready;
            c_PORT_BR:  w_sel_ready = br_ready;
            default:    w_sel_ready = 1'b0;
        endcase
    end

    assign w_deq = out_valid & w_sel_ready & ~flush & ~reset;

    // Write the accepted micro-op and its tag into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_uop_mem[r_wr_ptr] <= in_uop;
            r_cmd_mem[r_wr_ptr] <= in_cmdType;
            r_tag_mem[r_wr_ptr] <= r_next_tag;
        end
    end

    // Pointer, occupancy and tag bookkeeping; reset beats flush beats traffic.
    // A flush empties the queue but keeps the tag counter running so tags
    // already handed to the ROB are not reissued.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_next_tag <= '0;
        end else if (flush) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr   <= r_wr_ptr + c_PTR_ONE;
                r_next_tag <= r_next_tag + c_TAG_ONE;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispatch_queue
// Description : Self-checking bench for dispatch_queue; directed scenarios
//               plus randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispatch_queue;

    localparam int DEPTH = 4;
    localparam int UOP_W = 24;
    localparam int TAG_W = 4;
    localparam int NTAGS = 1 << TAG_W;

    logic             clk = 1'b0;
    logic             reset, flush, in_valid, rob_alloc_ok;
    logic [UOP_W-1:0] in_uop;
    logic [2:0]       in_cmdType;
    logic             alu_ready, mem_ready, br_ready;
    logic             in_ready, out_valid;
    logic [UOP_W-1:0] out_uop;
    logic [2:0]       out_cmdType;
    logic [TAG_W-1:0] out_tag;
    logic [1:0]       out_port;
    logic [2:0]       count;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [UOP_W-1:0] uop;
        logic [2:0]       cmd;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t m_q[$];
    int   m_tag = 0;

    dispatch_queue #(.DEPTH(DEPTH), .UOP_W(UOP_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_uop(in_uop),
        .in_cmdType(in_cmdType), .rob_alloc_ok(rob_alloc_ok),
        .out_valid(out_valid), .out_uop(out_uop), .out_cmdType(out_cmdType),
        .out_tag(out_tag), .out_port(out_port),
        .alu_ready(alu_ready), .mem_ready(mem_ready), .br_ready(br_ready),
        .count(count)
    );

    always #5 clk = ~clk;

    // Station table: 0,2,4 -> ALU; 1 -> memory; everything else -> branch.
    function automatic logic [1:0] port_of(input logic [2:0] c);
        if (c == 3'd0 || c == 3'd2 || c == 3'd4) return 2'd0;
        if (c == 3'd1) return 2'd1;
        return 2'd2;
    endfunction

    function automatic bit m_in_ready();
        return (m_q.size() < DEPTH) && rob_alloc_ok && !flush && !reset;
    endfunction

    function automatic bit m_station_ready(input logic [2:0] c);
        case (port_of(c))
            2'd0:    return alu_ready;
            2'd1:    return mem_ready;
            default: return br_ready;
        endcase
    endfunction

    // Advance one clock and apply the same transaction to the model.
    task automatic tick();
        bit   e, d;
        ent_t ent, junk;
        e = in_valid && m_in_ready();
        d = (m_q.size() > 0) && !flush && !reset && m_station_ready(m_q[0].cmd);
        ent.uop = in_uop;
        ent.cmd = in_cmdType;
        ent.tag = TAG_W'(m_tag);
        @(posedge clk);
        #1;
        if (reset) begin
            m_q.delete();
            m_tag = 0;
        end else if (flush) begin
            m_q.delete();
        end else begin
            if (d) junk = m_q.pop_front();
            if (e) begin
                m_q.push_back(ent);
                m_tag = (m_tag + 1) % NTAGS;
            end
        end
    endtask

    task automatic set_idle();
        reset = 0; flush = 0; in_valid = 0; rob_alloc_ok = 1;
        in_uop = '0; in_cmdType = 3'd0;
        alu_ready = 0; mem_ready = 0; br_ready = 0;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic enq_n(input int n, input logic [2:0] c);
        for (int i = 0; i < n; i++) begin
            in_valid = 1; in_uop = UOP_W'($urandom); in_cmdType = c;
            tick();
        end
        in_valid = 0;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1; in_valid = 1; alu_ready = 1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        tick();
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        // Reset with a full queue, flush and traffic all pending at once.
        set_idle();
        enq_n(4, 3'd0);
        #1;
        total++; if (count !== 3'd4) begin bad++; $display("FAIL reset_fill: got %0d want 4", count); end
        reset = 1; flush = 1; in_valid = 1; alu_ready = 1;
        tick();
        set_idle();
        #1;
        total++; if (count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL reset_full_prio: got count=%0d valid=%0b want 0/0", count, out_valid); end
        enq_n(1, 3'd1);
        #1;
        total++; if (out_tag !== 4'd0) begin bad++; $display("FAIL reset_tag: got %0d want 0", out_tag); end
    endtask

    task automatic test_basic();
        logic [UOP_W-1:0] uops [3];
        logic [2:0]       cmds [3];
        logic [1:0]       ports[3];
        uops[0] = 24'hA0A0A0; uops[1] = 24'hB1B1B1; uops[2] = 24'hC2C2C2;
        cmds[0] = 3'd0; cmds[1] = 3'd1; cmds[2] = 3'd3;
        ports[0] = 2'd0; ports[1] = 2'd1; ports[2] = 2'd2;
        do_reset();
        alu_ready = 1; mem_ready = 1; br_ready = 1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_empty: got %0b want 0", out_valid); end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_uop = uops[i]; in_cmdType = cmds[i];
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready[%0d]: got %0b want 1", i, in_ready); end
            tick();
            total++;
            if (out_valid !== 1'b1 || out_tag !== 4'(i) || out_port !== ports[i] || out_uop !== uops[i]) begin
                bad++;
                $display("FAIL basic_head[%0d]: got v=%0b tag=%0d port=%0d uop=%h want 1/%0d/%0d/%h",
                         i, out_valid, out_tag, out_port, out_uop, i, ports[i], uops[i]);
            end
        end
        in_valid = 0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drained: got %0b want 0", out_valid); end
    endtask

    task automatic test_full();
        do_reset();
        enq_n(4, 3'd2);
        #1;
        total++; if (count !== 3'd4 || in_ready !== 1'b0) begin bad++; $display("FAIL full_state: got count=%0d rdy=%0b want 4/0", count, in_ready); end
        in_valid = 1; in_cmdType = 3'd0; alu_ready = 1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_refuse: got %0b want 0", in_ready); end
        tick();
        in_valid = 0; alu_ready = 0;
        #1;
        total++; if (count !== 3'd3) begin bad++; $display("FAIL full_deq_only: got %0d want 3", count); end
        total++; if (out_tag !== 4'd1) begin bad++; $display("FAIL full_next_head: got %0d want 1", out_tag); end
    endtask

    task automatic test_stall();
        do_reset();
        enq_n(1, 3'd5);
        enq_n(1, 3'd0);
        alu_ready = 1; mem_ready = 1; br_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_tag !== 4'd0 || out_cmdType !== 3'd5 || count !== 3'd2) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got v=%0b tag=%0d cmd=%0d cnt=%0d want 1/0/5/2",
                         i, out_valid, out_tag, out_cmdType, count);
            end
        end
        br_ready = 1; alu_ready = 0;
        tick();
        total++; if (out_tag !== 4'd1 || count !== 3'd1) begin bad++; $display("FAIL stall_release: got tag=%0d cnt=%0d want 1/1", out_tag, count); end
    endtask

    task automatic test_wrap();
        do_reset();
        alu_ready = 1; mem_ready = 1; br_ready = 1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1; in_uop = UOP_W'(i * 3 + 1); in_cmdType = 3'(i % 8);
            tick();
            total++;
            if (out_valid !== 1'b1 || out_tag !== 4'(i % NTAGS) || out_uop !== UOP_W'(i * 3 + 1)) begin
                bad++;
                $display("FAIL wrap_tag[%0d]: got v=%0b tag=%0d uop=%0d want 1/%0d/%0d",
                         i, out_valid, out_tag, out_uop, i % NTAGS, i * 3 + 1);
            end
        end
        in_valid = 0;
        tick();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL wrap_empty: got %0d want 0", count); end
    endtask

    task automatic test_flush();
        do_reset();
        enq_n(4, 3'd0);
        alu_ready = 1;
        for (int i = 0; i < 4; i++) tick();
        alu_ready = 0;
        enq_n(3, 3'd4);
        #1;
        total++; if (count !== 3'd3) begin bad++; $display("FAIL flush_setup: got %0d want 3", count); end
        flush = 1; in_valid = 1; in_cmdType = 3'd1; alu_ready = 1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %0b want 0", in_ready); end
        tick();
        flush = 0; in_valid = 0; alu_ready = 0;
        #1;
        total++; if (count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_clear: got cnt=%0d v=%0b want 0/0", count, out_valid); end
        enq_n(1, 3'd1);
        total++; if (out_tag !== 4'd7) begin bad++; $display("FAIL flush_tag: got %0d want 7", out_tag); end
    endtask

    task automatic test_rob();
        do_reset();
        enq_n(2, 3'd0);
        rob_alloc_ok = 0; in_valid = 1; in_cmdType = 3'd0; alu_ready = 1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rob_in_ready: got %0b want 0", in_ready); end
        tick();
        total++; if (count !== 3'd1) begin bad++; $display("FAIL rob_drain1: got %0d want 1", count); end
        tick();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL rob_drain0: got %0d want 0", count); end
        set_idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            reset        = ($urandom_range(0, 99) == 0);
            flush        = ($urandom_range(0, 39) == 0);
            in_valid     = ($urandom_range(0, 3) != 0);
            in_uop       = UOP_W'($urandom);
            in_cmdType   = 3'($urandom);
            rob_alloc_ok = ($urandom_range(0, 7) != 0);
            alu_ready    = ($urandom_range(0, 2) != 0);
            mem_ready    = ($urandom_range(0, 2) != 0);
            br_ready     = ($urandom_range(0, 2) != 0);
            #1;
            total++; if (in_ready !== m_in_ready()) begin bad++; $display("FAIL rnd_in_ready@%0d: got %0b want %0b", cyc, in_ready, m_in_ready()); end
            total++; if (count !== 3'(m_q.size()) || out_valid !== (m_q.size() > 0)) begin
                bad++; $display("FAIL rnd_count@%0d: got cnt=%0d v=%0b want %0d", cyc, count, out_valid, m_q.size());
            end
            if (m_q.size() > 0) begin
                total++;
                if (out_tag !== m_q[0].tag || out_uop !== m_q[0].uop || out_cmdType !== m_q[0].cmd || out_port !== port_of(m_q[0].cmd)) begin
                    bad++;
                    $display("FAIL rnd_head@%0d: got tag=%0d uop=%h cmd=%0d port=%0d want %0d/%h/%0d/%0d", cyc,
                             out_tag, out_uop, out_cmdType, out_port, m_q[0].tag, m_q[0].uop, m_q[0].cmd, port_of(m_q[0].cmd));
                end
            end
            tick();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_basic();
        test_full();
        test_stall();
        test_wrap();
        test_flush();
        test_rob();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
